// File: rtl/accel_apb_slv_pkg.sv
// State encoding and register bundle for the accel_apb_slv APB responder.
package accel_apb_slv_pkg;

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    Request  = 2'd1,
    WaitResp = 2'd2,
    Out      = 2'd3
  } accel_apb_slv_state_t;

  typedef struct packed {
    accel_apb_slv_state_t state;
    logic                 req_valid;
    logic [31:0]          req_addr;
    logic                 req_write;
    logic [31:0]          req_wdata;
    logic [3:0]           req_wstrb;
    logic [31:0]          resp_rdata;
    logic                 resp_err;
    logic                 pready;
    logic [7:0]           tmo_cnt;
  } accel_apb_slv_registers;

  localparam accel_apb_slv_registers accel_apb_slv_r_reset = '{
    state:      Idle,
    req_valid:  1'b0,
    req_addr:   '0,
    req_write:  1'b0,
    req_wdata:  '0,
    req_wstrb:  '0,
    resp_rdata: '0,
    resp_err:   1'b0,
    pready:     1'b0,
    tmo_cnt:    '0
  };

endpackage

// File: rtl/types_amba_pkg.sv
// AMBA bus types shared by bus1 peripherals: APB request/response and memory-map slot.
package types_amba_pkg;

  typedef struct packed {
    logic [63:0] addr_start;
    logic [63:0] addr_end;
  } mapinfo_type;

  typedef struct packed {
    logic        pselx;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } apb_in_type;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_out_type;

endpackage

// File: rtl/types_pnp_pkg.sv
// Plug-and-play descriptor types published by bus1 slaves.
package types_pnp_pkg;

  localparam logic [1:0] PNP_CFG_TYPE_SLAVE      = 2'h2;
  localparam logic [7:0] PNP_CFG_DEV_DESCR_BYTES = 8'h20;

  typedef struct packed {
    logic [7:0]  descrsize;
    logic [1:0]  descrtype;
    logic [63:0] addr_start;
    logic [63:0] addr_end;
    logic [15:0] vid;
    logic [15:0] did;
  } dev_config_type;

endpackage

// File: rtl/accel_apb_slv.sv
// APB responder: converts each APB transfer into one req/resp handshake and publishes the PnP descriptor.
// Optional response timeout enabled by defining ACCEL_APB_SLV_TIMEOUT_EN.
module accel_apb_slv
  import types_amba_pkg::*, types_pnp_pkg::*, accel_apb_slv_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID      = 16'h00F1,
  parameter logic [15:0] DEVICE_ID      = 16'h0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic           i_clk,
  input  logic           i_nrst,
  input  mapinfo_type    i_mapinfo,
  output dev_config_type o_cfg,
  input  apb_in_type     i_apbi,
  output apb_out_type    o_apbo,
  output logic           o_req_valid,
  output logic [31:0]    o_req_addr,
  output logic           o_req_write,
  output logic [31:0]    o_req_wdata,
  output logic [3:0]     o_req_wstrb,
  input  logic           i_resp_valid,
  input  logic [31:0]    i_resp_rdata,
  input  logic           i_resp_err
);

  accel_apb_slv_registers r;
  accel_apb_slv_registers rin;
  accel_apb_slv_registers v;

  // req_valid and pready are one-cycle strobes registered on entry to Request / Out.
  always_comb begin
    v = r;
    v.req_valid = 1'b0;
    v.pready = 1'b0;
    case (r.state)
      Idle: begin
        if (i_apbi.pselx) begin
          v.state = Request;
          v.req_valid = 1'b1;
          v.req_addr = i_apbi.paddr - i_mapinfo.addr_start[31:0];
          v.req_write = i_apbi.pwrite;
          v.req_wdata = i_apbi.pwdata;
          v.req_wstrb = i_apbi.pstrb;
          v.tmo_cnt = '0;
        end
      end
      Request: begin
        if (i_resp_valid) begin
          v.state = Out;
          v.pready = 1'b1;
          v.resp_rdata = i_resp_rdata;
          v.resp_err = i_resp_err;
        end else begin
          v.state = WaitResp;
        end
      end
      WaitResp: begin
        if (i_resp_valid) begin
          v.state = Out;
          v.pready = 1'b1;
          v.resp_rdata = i_resp_rdata;
          v.resp_err = i_resp_err;
        end
`ifdef ACCEL_APB_SLV_TIMEOUT_EN
        else if (r.tmo_cnt == TIMEOUT_CYCLES) begin
          v.state = Out;
          v.pready = 1'b1;
          v.resp_rdata = '0;
          v.resp_err = 1'b1;
        end else begin
          v.tmo_cnt = r.tmo_cnt + 8'd1;
        end
`endif
      end
      Out: begin
        v.state = Idle;
      end
      default: begin
        v.state = Idle;
      end
    endcase
    rin = v;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r <= accel_apb_slv_r_reset;
    end else begin
      r <= rin;
    end
  end

  always_comb begin
    o_cfg = '0;
    o_cfg.descrsize = PNP_CFG_DEV_DESCR_BYTES;
    o_cfg.descrtype = PNP_CFG_TYPE_SLAVE;
    o_cfg.addr_start = i_mapinfo.addr_start;
    o_cfg.addr_end = i_mapinfo.addr_end;
    o_cfg.vid = VENDOR_ID;
    o_cfg.did = DEVICE_ID;
  end

  assign o_apbo.prdata = r.resp_rdata;
  assign o_apbo.pready = r.pready;
  assign o_apbo.pslverr = r.resp_err;
  assign o_req_valid = r.req_valid;
  assign o_req_addr = r.req_addr;
  assign o_req_write = r.req_write;
  assign o_req_wdata = r.req_wdata;
  assign o_req_wstrb = r.req_wstrb;

  logic unused_apb;
`ifdef ACCEL_APB_SLV_TIMEOUT_EN
  assign unused_apb = &{1'b0, i_apbi.penable, i_apbi.pprot};
`else
  assign unused_apb = &{1'b0, i_apbi.penable, i_apbi.pprot, TIMEOUT_CYCLES};
`endif

endmodule
